// File: rtl/filter_sequencer_if.sv
// filter_sequencer_if
//   Groups the symbol handshake, filter control/data and output sample
//   signals of the polyphase filter sequencer.
//   master : the sequencer (consumes symbols/ticks/filter results, drives
//            filter control, delay lines and output samples)
//   slave  : the surrounding environment (mapper, filter, DAC side)
//   Signals:
//     RUN, TICK                  sample-rate control
//     SYM_VALID/SYM_READY        symbol pair handshake, SYM_I/SYM_Q codes
//     FILT_ENABLE, FILT_STAGE    filter control, STAGE = {phase, iq}
//     FILT_INPUT_I/Q             delay lines to the filter
//     FILT_OUT_I/Q               registered filter results
//     SAMPLE_VALID, SAMPLE_I/Q   output sample strobe and data
//     UNDERRUN, OVERRUN          one-cycle status pulses
interface filter_sequencer_if #(
  parameter int TAPS   = 17,
  parameter int PHASES = 4,
  parameter int OUT_W  = 13
);
  localparam int LINE_W  = 2 * TAPS;
  localparam int STAGE_W = $clog2(PHASES) + 1;

  logic                     RUN;
  logic                     TICK;
  logic                     SYM_VALID;
  logic [1:0]               SYM_I;
  logic [1:0]               SYM_Q;
  logic                     SYM_READY;
  logic                     FILT_ENABLE;
  logic [STAGE_W-1:0]       FILT_STAGE;
  logic [LINE_W-1:0]        FILT_INPUT_I;
  logic [LINE_W-1:0]        FILT_INPUT_Q;
  logic signed [OUT_W-1:0]  FILT_OUT_I;
  logic signed [OUT_W-1:0]  FILT_OUT_Q;
  logic                     SAMPLE_VALID;
  logic signed [OUT_W-1:0]  SAMPLE_I;
  logic signed [OUT_W-1:0]  SAMPLE_Q;
  logic                     UNDERRUN;
  logic                     OVERRUN;

  modport master (
    input  RUN, TICK, SYM_VALID, SYM_I, SYM_Q, FILT_OUT_I, FILT_OUT_Q,
    output SYM_READY, FILT_ENABLE, FILT_STAGE, FILT_INPUT_I, FILT_INPUT_Q,
           SAMPLE_VALID, SAMPLE_I, SAMPLE_Q, UNDERRUN, OVERRUN
  );

  modport slave (
    output RUN, TICK, SYM_VALID, SYM_I, SYM_Q, FILT_OUT_I, FILT_OUT_Q,
    input  SYM_READY, FILT_ENABLE, FILT_STAGE, FILT_INPUT_I, FILT_INPUT_Q,
           SAMPLE_VALID, SAMPLE_I, SAMPLE_Q, UNDERRUN, OVERRUN
  );
endinterface

// File: rtl/filter_sequencer.sv
// filter_sequencer
//   Sequences a shared I/Q polyphase interpolation filter. One symbol pair
//   is accepted per PHASES output samples and shifted into two symbol delay
//   lines. Each accepted TICK walks the filter through the I then Q stage of
//   the current phase and registers the filter results as one output sample.
//   Ports:
//     CLK  system clock
//     RST  synchronous, active-high reset
//     bus  filter_sequencer_if.master (handshake, filter and sample signals)
module filter_sequencer #(
  parameter int TAPS   = 17,
  parameter int PHASES = 4,
  parameter int OUT_W  = 13
) (
  input logic                CLK,
  input logic                RST,
  filter_sequencer_if.master bus
);
  localparam int LINE_W = 2 * TAPS;
  localparam int PH_W   = $clog2(PHASES);

  typedef enum logic [1:0] {IDLE, CALC_I, CALC_Q, OUT} state_t;

  state_t                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [LINE_W-1:0]       line_i_q, line_i_d;
  logic [LINE_W-1:0]       line_q_q, line_q_d;
  logic                    en_q, en_d;
  logic [PH_W:0]           stage_q, stage_d;
  logic                    svalid_q, svalid_d;
  logic signed [OUT_W-1:0] sample_i_q, sample_i_d;
  logic signed [OUT_W-1:0] sample_q_q, sample_q_d;
  logic                    underrun_q, underrun_d;
  logic                    overrun_q, overrun_d;

  logic                    accept;
  logic                    sym_ready;
  logic [1:0]              new_i, new_q;

  // A tick is taken only from IDLE while running; symbols load on phase 0.
  assign accept    = (state_q == IDLE) & bus.RUN & bus.TICK;
  assign sym_ready = accept & (phase_q == '0);
  // Missing symbol becomes a zero code so the line still advances in time.
  assign new_i     = bus.SYM_VALID ? bus.SYM_I : 2'b00;
  assign new_q     = bus.SYM_VALID ? bus.SYM_Q : 2'b00;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    line_i_d   = line_i_q;
    line_q_d   = line_q_q;
    sample_i_d = sample_i_q;
    sample_q_d = sample_q_q;
    svalid_d   = 1'b0;
    underrun_d = 1'b0;
    overrun_d  = 1'b0;
    en_d       = 1'b0;
    stage_d    = stage_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = CALC_I;
        if (sym_ready) begin
          line_i_d   = {line_i_q[LINE_W-3:0], new_i};
          line_q_d   = {line_q_q[LINE_W-3:0], new_q};
          underrun_d = ~bus.SYM_VALID;
        end
      end
      CALC_I: state_d = CALC_Q;
      CALC_Q: state_d = OUT;
      OUT: begin
        state_d    = IDLE;
        sample_i_d = bus.FILT_OUT_I;
        sample_q_d = bus.FILT_OUT_Q;
        svalid_d   = 1'b1;
        phase_d    = (phase_q == PH_W'(PHASES - 1)) ? '0 : phase_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Busy tick while running is dropped and flagged; RUN=0 ticks are silent.
    if (bus.TICK && bus.RUN && (state_q != IDLE)) overrun_d = 1'b1;

    // Filter controls are registered from the next state so they line up
    // with CALC_I/CALC_Q; STAGE holds its last value outside computation.
    if (state_d == CALC_I) begin
      en_d    = 1'b1;
      stage_d = {phase_q, 1'b0};
    end else if (state_d == CALC_Q) begin
      en_d    = 1'b1;
      stage_d = {phase_q, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      line_i_q   <= '0;
      line_q_q   <= '0;
      en_q       <= 1'b0;
      stage_q    <= '0;
      svalid_q   <= 1'b0;
      sample_i_q <= '0;
      sample_q_q <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      line_i_q   <= line_i_d;
      line_q_q   <= line_q_d;
      en_q       <= en_d;
      stage_q    <= stage_d;
      svalid_q   <= svalid_d;
      sample_i_q <= sample_i_d;
      sample_q_q <= sample_q_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.SYM_READY    = sym_ready;
  assign bus.FILT_ENABLE  = en_q;
  assign bus.FILT_STAGE   = stage_q;
  assign bus.FILT_INPUT_I = line_i_q;
  assign bus.FILT_INPUT_Q = line_q_q;
  assign bus.SAMPLE_VALID = svalid_q;
  assign bus.SAMPLE_I     = sample_i_q;
  assign bus.SAMPLE_Q     = sample_q_q;
  assign bus.UNDERRUN     = underrun_q;
  assign bus.OVERRUN      = overrun_q;
endmodule
